// File: rtl/led_scan_pkg.sv
// Shared mode encodings and sizing helpers for the LED scanner.
package led_scan_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    // speed 3 is the base period; each step down doubles it
    function automatic logic [1:0] speed_shift(input logic [1:0] speed);
        return 2'd3 - speed;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned clk_div);
        return $clog2(8 * clk_div);
    endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Switch/button inputs and LED drive outputs of the scanner.
interface led_scan_ctrl_if;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;
    logic [7:0] led_out;
    logic       dir_out;
    logic       step;

    modport master (output mode, speed, pause, input led_out, dir_out, step);
    modport slave  (input mode, speed, pause, output led_out, dir_out, step);
endinterface

// File: rtl/led_tick_gen.sv
// Step prescaler: terminal period CLK_DIV << (3 - speed), frozen by pause, cleared by clr.
module led_tick_gen
    import led_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic       pause,
    input  logic       clr,
    output logic       tick
);

    localparam int unsigned CW = cnt_width(CLK_DIV);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   term_t;

    cnt_t  cnt_q, cnt_d;
    term_t term;

    // >= rather than == so a speed change below the current count ticks at once
    always_comb begin
        term  = term_t'(CLK_DIV) << speed_shift(speed);
        tick  = !pause && !clr && ({1'b0, cnt_q} >= term - term_t'(1));
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!pause) begin
            cnt_d = tick ? '0 : cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// 8-LED scanner sequencer: 10-bit comet pattern with bounce/rotate/blink/off modes.
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 12_500_000,
    parameter logic [9:0]  LEDS_INIT = 10'b1100000000,
    parameter logic        DIR_INIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    led_scan_ctrl_if.slave   bus
);

    mode_e      mode_in;
    mode_e      mode_q, mode_d;
    logic [9:0] leds_q, leds_d;
    logic       dir_q, dir_d;
    logic       ph_q, ph_d;
    logic [7:0] led_out_q, led_out_d;
    logic       dir_out_q, dir_out_d;
    logic       step_q, step_d;
    logic       mode_chg;
    logic       tick;

    assign mode_in  = mode_e'(bus.mode);
    assign mode_chg = (mode_in != mode_q);

    led_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .speed (bus.speed),
        .pause (bus.pause),
        .clr   (mode_chg),
        .tick  (tick)
    );

    always_comb begin
        mode_d    = mode_q;
        leds_d    = leds_q;
        dir_d     = dir_q;
        ph_d      = ph_q;
        step_d    = 1'b0;
        led_out_d = led_out_q;
        dir_out_d = dir_out_q;

        if (mode_chg) begin
            mode_d = mode_in;
            leds_d = LEDS_INIT;
            dir_d  = DIR_INIT;
            ph_d   = 1'b0;
        end else if (tick) begin
            step_d = 1'b1;
            case (mode_q)
                // guard bits [9] and [0] let the comet slide fully off the visible edge
                MODE_BOUNCE: begin
                    if (dir_q) begin
                        if (leds_q[0]) begin
                            dir_d  = 1'b0;
                            leds_d = leds_q << 1;
                        end else begin
                            leds_d = leds_q >> 1;
                        end
                    end else begin
                        if (leds_q[9]) begin
                            dir_d  = 1'b1;
                            leds_d = leds_q >> 1;
                        end else begin
                            leds_d = leds_q << 1;
                        end
                    end
                end
                MODE_ROTATE: leds_d = dir_q ? {leds_q[0], leds_q[9:1]}
                                            : {leds_q[8:0], leds_q[9]};
                MODE_BLINK:  ph_d   = ~ph_q;
                default:     ;
            endcase
        end

        // outputs only move with a state update, so the reset image persists until then
        if (mode_chg || tick) begin
            dir_out_d = dir_d;
            case (mode_d)
                MODE_BOUNCE, MODE_ROTATE: led_out_d = leds_d[8:1];
                MODE_BLINK:               led_out_d = {8{ph_d}};
                default:                  led_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= mode_in;
            leds_q    <= LEDS_INIT;
            dir_q     <= DIR_INIT;
            ph_q      <= 1'b0;
            step_q    <= 1'b0;
            dir_out_q <= DIR_INIT;
            led_out_q <= LEDS_INIT[8:1];
        end else begin
            mode_q    <= mode_d;
            leds_q    <= leds_d;
            dir_q     <= dir_d;
            ph_q      <= ph_d;
            step_q    <= step_d;
            dir_out_q <= dir_out_d;
            led_out_q <= led_out_d;
        end
    end

    assign bus.led_out = led_out_q;
    assign bus.dir_out = dir_out_q;
    assign bus.step    = step_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: comet-position model checked every cycle plus directed literal checks.
module tb_led_scan_ctrl;

    localparam int CD = 4;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;

    int checks   = 0;
    int failures = 0;

    led_scan_ctrl_if ifa ();
    led_scan_ctrl_if ifb ();

    assign ifa.mode  = mode;
    assign ifa.speed = speed;
    assign ifa.pause = pause;
    assign ifb.mode  = mode;
    assign ifb.speed = speed;
    assign ifb.pause = pause;

    led_scan_ctrl #(.CLK_DIV(CD)) u_dut (.clk(clk), .rst(rst), .bus(ifa));
    led_scan_ctrl #(.CLK_DIV(CD), .DIR_INIT(1'b0)) u_rot (.clk(clk), .rst(rst), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: comet is bits pos and pos+1 (mod 10) of the 10-bit pattern; pos 8 = init.
    int         m_pos[2];
    int         m_cnt[2];
    bit         m_ph[2];
    bit         m_dir[2];
    logic [1:0] m_mode[2];
    logic [7:0] e_led[2];
    bit         e_dir[2];
    bit         e_step[2];
    bit         seen_rst = 1'b0;

    function automatic logic [7:0] show(input int i);
        logic [9:0] v;
        v = '0;
        v[m_pos[i]] = 1'b1;
        v[(m_pos[i] + 1) % 10] = 1'b1;
        case (m_mode[i])
            2'd0, 2'd1: return v[8:1];
            2'd2:       return m_ph[i] ? 8'hFF : 8'h00;
            default:    return 8'h00;
        endcase
    endfunction

    function automatic void advance(input int i);
        case (m_mode[i])
            2'd0: begin
                if (m_dir[i]) begin
                    if (m_pos[i] == 0) begin m_dir[i] = 1'b0; m_pos[i] = 1; end
                    else m_pos[i] = m_pos[i] - 1;
                end else begin
                    if (m_pos[i] == 8) begin m_dir[i] = 1'b1; m_pos[i] = 7; end
                    else m_pos[i] = m_pos[i] + 1;
                end
            end
            2'd1:    m_pos[i] = m_dir[i] ? (m_pos[i] + 9) % 10 : (m_pos[i] + 1) % 10;
            2'd2:    m_ph[i] = ~m_ph[i];
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        int period;
        for (int i = 0; i < 2; i++) begin
            e_step[i] = 1'b0;
            if (rst) begin
                m_pos[i]  = 8;
                m_dir[i]  = (i == 0);
                m_ph[i]   = 1'b0;
                m_cnt[i]  = 0;
                m_mode[i] = mode;
                e_led[i]  = 8'h80;
                e_dir[i]  = m_dir[i];
                seen_rst  = 1'b1;
            end else if (mode != m_mode[i]) begin
                m_mode[i] = mode;
                m_pos[i]  = 8;
                m_dir[i]  = (i == 0);
                m_ph[i]   = 1'b0;
                m_cnt[i]  = 0;
                e_led[i]  = show(i);
                e_dir[i]  = m_dir[i];
            end else if (!pause) begin
                period   = CD * (1 << (3 - int'(speed)));
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] >= period) begin
                    m_cnt[i]  = 0;
                    advance(i);
                    e_step[i] = 1'b1;
                    e_led[i]  = show(i);
                    e_dir[i]  = m_dir[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (seen_rst) begin
            chk("model_led_a",  ifa.led_out, e_led[0]);
            chk("model_dir_a",  ifa.dir_out, e_dir[0]);
            chk("model_step_a", ifa.step,    e_step[0]);
            chk("model_led_b",  ifb.led_out, e_led[1]);
            chk("model_dir_b",  ifb.dir_out, e_dir[1]);
            chk("model_step_b", ifb.step,    e_step[1]);
        end
    end

    // Returns edges elapsed until step is seen high (sampled at negedge).
    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ifa.step && n < 200);
        if (!ifa.step) begin
            checks++;
            failures++;
            $display("FAIL step_timeout: no step within %0d cycles at %0t", n, $time);
        end
    endtask

    logic [7:0] bseq [16] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h01,
                              8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h80};
    logic [7:0] rot_b [4]  = '{8'h00, 8'h01, 8'h03, 8'h06};
    logic [7:0] rot_a [4]  = '{8'hC0, 8'h60, 8'h30, 8'h18};

    initial begin
        int n;
        logic [7:0] held;

        rst = 1'b1; mode = 2'b00; speed = 2'd3; pause = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_led", ifa.led_out, 8'h80);
        chk("rst_dir", ifa.dir_out, 1);
        chk("rst_step", ifa.step, 0);
        chk("rst_dir_b", ifb.dir_out, 0);

        // bounce: first step on 4th edge, then 16-step cycle
        wait_step(n);
        chk("first_step_edges", n, 4);
        chk("bounce_led_1", ifa.led_out, bseq[0]);
        chk("bounce_dir_1", ifa.dir_out, 1);
        for (int k = 1; k < 16; k++) begin
            wait_step(n);
            chk($sformatf("bounce_gap_%0d", k + 1), n, 4);
            chk($sformatf("bounce_led_%0d", k + 1), ifa.led_out, bseq[k]);
            chk($sformatf("bounce_dir_%0d", k + 1), ifa.dir_out, (k < 8) ? 1 : 0);
        end
        wait_step(n);
        chk("bounce_led_17", ifa.led_out, 8'hC0);
        chk("bounce_dir_17", ifa.dir_out, 1);

        // slowest speed, then speed-up mid count
        speed = 2'd0;
        wait_step(n);
        chk("speed0_gap", n, 32);
        repeat (20) @(negedge clk);
        speed = 2'd3;
        wait_step(n);
        chk("speedup_gap", n, 1);

        // pause stretches spacing by its length
        held = ifa.led_out;
        repeat (2) @(negedge clk);
        pause = 1'b1;
        repeat (10) @(negedge clk);
        chk("pause_hold_led", ifa.led_out, held);
        pause = 1'b0;
        wait_step(n);
        chk("pause_spacing", 12 + n, 14);

        // bounce -> blink mid count
        repeat (2) @(negedge clk);
        mode = 2'b10;
        @(negedge clk);
        chk("blink_entry_led", ifa.led_out, 8'h00);
        chk("blink_entry_step", ifa.step, 0);
        wait_step(n);
        chk("blink_gap_1", n, 4);
        chk("blink_led_1", ifa.led_out, 8'hFF);
        wait_step(n);
        chk("blink_gap_2", n, 4);
        chk("blink_led_2", ifa.led_out, 8'h00);

        // mode change on the would-be tick edge
        repeat (3) @(negedge clk);
        mode = 2'b11;
        @(negedge clk);
        chk("collide_step", ifa.step, 0);
        chk("off_led", ifa.led_out, 8'h00);
        wait_step(n);
        chk("off_gap", n, 4);
        chk("off_led_step", ifa.led_out, 8'h00);

        // rotate: DIR_INIT=0 instance rotates left, default rotates right
        mode = 2'b01;
        @(negedge clk);
        chk("rot_entry_b", ifb.led_out, 8'h80);
        chk("rot_entry_a", ifa.led_out, 8'h80);
        for (int k = 0; k < 4; k++) begin
            wait_step(n);
            chk($sformatf("rot_gap_%0d", k + 1), n, 4);
            chk($sformatf("rot_b_led_%0d", k + 1), ifb.led_out, rot_b[k]);
            chk($sformatf("rot_a_led_%0d", k + 1), ifa.led_out, rot_a[k]);
            chk($sformatf("rot_b_dir_%0d", k + 1), ifb.dir_out, 0);
        end

        // mode change while paused, then reset mid blink with pause high
        mode = 2'b10;
        @(negedge clk);
        wait_step(n);
        chk("blink2_led", ifa.led_out, 8'hFF);
        pause = 1'b1;
        mode  = 2'b00;
        @(negedge clk);
        chk("paused_modechg_led", ifa.led_out, 8'h80);
        chk("paused_modechg_step", ifa.step, 0);
        mode = 2'b10;
        @(negedge clk);
        chk("paused_blink_led", ifa.led_out, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_led", ifa.led_out, 8'h80);
        chk("midrst_dir", ifa.dir_out, 1);
        chk("midrst_step", ifa.step, 0);
        chk("midrst_led_b", ifb.led_out, 8'h80);
        chk("midrst_dir_b", ifb.dir_out, 0);
        rst   = 1'b0;
        pause = 1'b0;
        wait_step(n);
        chk("post_rst_gap", n, 4);
        chk("post_rst_led", ifa.led_out, 8'hFF);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, failures=%0d", failures);
        $fatal(1, "timeout");
    end

endmodule
